// File: rtl/mdr_result_collector.sv
// Result collector for the multiply/divide/root units: tracks one outstanding
// operation, captures the selected unit's result/remainder on its ready pulse,
// buffers captures in a first-word-fall-through FIFO and aborts stalled
// operations after a configurable number of wait cycles.
//
//   state  | meaning
//   IDLE   | no operation outstanding; i_start with a valid unit launches one
//   WAIT   | waiting for i_ready of the latched unit, or for the timeout
module mdr_result_collector #(
    parameter int                 DW       = 32,
    parameter int                 N_UNITS  = 3,
    parameter int                 DEPTH    = 4,
    parameter logic [N_UNITS-1:0] REM_MASK = 3'b110,
    parameter int                 TIMEOUT  = 64,
    localparam int                SEL_W    = $clog2(N_UNITS + 1),
    localparam int                CW       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [N_UNITS*DW-1:0] i_result,
    input  logic [N_UNITS*DW-1:0] i_remainder,
    input  logic [N_UNITS-1:0]    i_ready,
    input  logic                  i_accept,
    output logic [DW-1:0]         o_result,
    output logic [DW-1:0]         o_remainder,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic [CW-1:0]         o_count,
    output logic                  o_full,
    output logic                  o_timeout,
    output logic                  o_overflow
);

    localparam int PW = $clog2(DEPTH);
    // A zero timeout disables the counter; keep it one bit wide in that case.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [TW-1:0]       r_tcnt;
    logic                r_timeout;
    logic                r_overflow;
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic [2*DW-1:0]     r_mem [DEPTH];

    logic                w_rdy;
    logic [DW-1:0]       w_res;
    logic [DW-1:0]       w_rem;
    logic                w_capture;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic [2*DW-1:0]     w_head;

    // Select the latched unit's ready, result and masked remainder.
    always_comb begin
        w_rdy = 1'b0;
        w_res = '0;
        w_rem = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (r_sel == SEL_W'(u)) begin
                w_rdy = i_ready[u];
                w_res = i_result[u*DW +: DW];
                w_rem = REM_MASK[u] ? i_remainder[u*DW +: DW] : '0;
            end
        end
    end

    assign w_capture = (r_state == S_WAIT) && w_rdy;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && i_accept;
    // When full, a capture still lands if the head leaves in the same cycle.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_head    = r_mem[r_rptr];

    // Operation tracking: launch, capture-or-timeout, one-cycle timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && (i_sel < SEL_W'(N_UNITS))) begin
                        r_sel   <= i_sel;
                        r_tcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_rdy) begin
                        r_state <= S_IDLE;
                    end else if ((TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1))) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_capture && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are not reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_res, w_rem};
    end

    assign o_valid     = !w_empty;
    assign o_full      = w_full;
    assign o_count     = r_count;
    assign o_busy      = (r_state == S_WAIT);
    assign o_timeout   = r_timeout;
    assign o_overflow  = r_overflow;
    assign o_result    = w_empty ? '0 : w_head[2*DW-1:DW];
    assign o_remainder = w_empty ? '0 : w_head[DW-1:0];

endmodule

// File: tb/tb_mdr_result_collector.sv
// Directed bench for mdr_result_collector with a queue scoreboard of expected
// {result, remainder} entries in FIFO order.
module tb_mdr_result_collector;

    localparam int       DW      = 32;
    localparam int       NU      = 3;
    localparam int       DEPTH   = 4;
    localparam logic [2:0] RMASK = 3'b110;
    localparam int       TOUT    = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start;
    logic [1:0]      i_sel;
    logic [NU*DW-1:0] i_result;
    logic [NU*DW-1:0] i_remainder;
    logic [NU-1:0]   i_ready;
    logic            i_accept;
    logic [DW-1:0]   o_result;
    logic [DW-1:0]   o_remainder;
    logic            o_valid;
    logic            o_busy;
    logic [2:0]      o_count;
    logic            o_full;
    logic            o_timeout;
    logic            o_overflow;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    mdr_result_collector #(
        .DW(DW), .N_UNITS(NU), .DEPTH(DEPTH), .REM_MASK(RMASK), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_sel(i_sel),
        .i_result(i_result), .i_remainder(i_remainder), .i_ready(i_ready),
        .i_accept(i_accept), .o_result(o_result), .o_remainder(o_remainder),
        .o_valid(o_valid), .o_busy(o_busy), .o_count(o_count), .o_full(o_full),
        .o_timeout(o_timeout), .o_overflow(o_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int sel);
        i_start = 1'b1;
        i_sel   = 2'(sel);
        cyc();
        i_start = 1'b0;
    endtask

    // Drive a ready pulse on unit u; optionally accept in the same cycle.
    task automatic ready(input int u, input logic [31:0] res, input logic [31:0] rem,
                         input bit acc);
        i_result[u*DW +: DW]    = res;
        i_remainder[u*DW +: DW] = rem;
        i_ready[u] = 1'b1;
        i_accept   = acc;
        cyc();
        i_ready  = '0;
        i_accept = 1'b0;
    endtask

    function automatic logic [63:0] expect_entry(input int u, input logic [31:0] res,
                                                 input logic [31:0] rem);
        return {res, (RMASK[u] ? rem : 32'h0)};
    endfunction

    task automatic chk_head(input string tag);
        chk({tag, "_valid"}, {63'h0, o_valid}, 64'h1);
        chk({tag, "_data"}, {o_result, o_remainder}, sb[0]);
    endtask

    task automatic pop_one(input string tag);
        chk_head(tag);
        i_accept = 1'b1;
        cyc();
        i_accept = 1'b0;
        void'(sb.pop_front());
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_outs"},
            {o_result, o_remainder[23:0], o_valid, o_busy, o_count, o_full, o_timeout, o_overflow},
            64'h0);
        chk({tag, "_rem_hi"}, {56'h0, o_remainder[31:24]}, 64'h0);
    endtask

    initial begin
        int n;
        rst = 1'b1; i_start = 1'b0; i_sel = '0; i_result = '0; i_remainder = '0;
        i_ready = '0; i_accept = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk_idle_outputs("reset");

        // Basic MULT; ready in the start cycle itself must be ignored.
        i_ready[0] = 1'b1;
        start(0);
        i_ready = '0;
        chk("mult_busy", {63'h0, o_busy}, 64'h1);
        chk("mult_noearly", {61'h0, o_count}, 64'h0);
        cyc(); cyc();
        ready(0, 32'h0000_0042, 32'h0000_DEAD, 1'b0);
        sb.push_back(expect_entry(0, 32'h42, 32'hDEAD));
        chk("mult_busy_clr", {63'h0, o_busy}, 64'h0);
        chk("mult_count", {61'h0, o_count}, 64'h1);
        pop_one("mult");
        chk("mult_empty", {o_result, o_remainder}, 64'h0);
        chk("mult_count0", {61'h0, o_count}, 64'h0);

        // Accept while empty has no effect.
        i_accept = 1'b1; cyc(); i_accept = 1'b0;
        chk("acc_empty", {61'h0, o_count}, 64'h0);

        // DIV with a stray ready from ROOT.
        start(1);
        ready(2, 32'h99, 32'h98, 1'b0);
        chk("div_stray_busy", {63'h0, o_busy}, 64'h1);
        chk("div_stray_cnt", {61'h0, o_count}, 64'h0);
        ready(1, 32'd7, 32'd3, 1'b0);
        sb.push_back(expect_entry(1, 32'd7, 32'd3));
        pop_one("div");

        // Fill to DEPTH without accepting.
        for (int i = 0; i < DEPTH; i++) begin
            start(1);
            ready(1, 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0);
            sb.push_back(expect_entry(1, 32'h100 + 32'(i), 32'h200 + 32'(i)));
        end
        chk("fill_count", {61'h0, o_count}, 64'(DEPTH));
        chk("fill_full", {63'h0, o_full}, 64'h1);
        chk("fill_noovf", {63'h0, o_overflow}, 64'h0);

        // Fifth capture is dropped.
        start(2);
        ready(2, 32'hBAD0, 32'hBAD1, 1'b0);
        chk("ovf_flag", {63'h0, o_overflow}, 64'h1);
        chk("ovf_count", {61'h0, o_count}, 64'(DEPTH));
        chk("ovf_busy", {63'h0, o_busy}, 64'h0);
        chk_head("ovf_head");

        // Full with simultaneous capture and pop, across pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            start(i % 3);
            chk_head("fullpop_head");
            ready(i % 3, 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b1);
            void'(sb.pop_front());
            sb.push_back(expect_entry(i % 3, 32'h300 + 32'(i), 32'h400 + 32'(i)));
            chk("fullpop_count", {61'h0, o_count}, 64'(DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) pop_one("drain");
        chk("drain_empty", {62'h0, o_valid, o_full}, 64'h0);
        chk("drain_ovf_sticky", {63'h0, o_overflow}, 64'h1);

        // Timeout with no ready.
        start(2);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            cyc();
            if (o_timeout) begin
                n = k;
                break;
            end
        end
        chk("tout_latency", 64'(n), 64'(TOUT));
        chk("tout_busy", {63'h0, o_busy}, 64'h0);
        chk("tout_nopush", {61'h0, o_count}, 64'h0);
        cyc();
        chk("tout_pulse_once", {63'h0, o_timeout}, 64'h0);
        ready(2, 32'h55, 32'h66, 1'b0);
        chk("tout_late_ready", {61'h0, o_count}, 64'h0);

        // Ready in the last allowed WAIT cycle is still captured.
        start(2);
        for (int k = 1; k < TOUT; k++) cyc();
        ready(2, 32'h777, 32'h888, 1'b0);
        sb.push_back(expect_entry(2, 32'h777, 32'h888));
        chk("tout_edge_notout", {63'h0, o_timeout}, 64'h0);
        pop_one("tout_edge");

        // NON selection.
        start(3);
        chk("non_busy", {63'h0, o_busy}, 64'h0);

        // Reset mid-WAIT abandons the operation.
        start(1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle_outputs("rst_wait");
        ready(1, 32'h12, 32'h34, 1'b0);
        chk("rst_wait_nopush", {62'h0, o_valid, o_busy}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdr_result_collector.md
# mdr_result_collector

Parametrised result-collection stage for the multiply/divide/root (MDR) datapath. It tracks one outstanding operation on one of `N_UNITS` arithmetic units and captures that unit's result and remainder on its ready pulse. Captured results go into a `DEPTH`-entry output FIFO, drained by a valid/accept handshake. It sits between the arithmetic units and the system output register, and adds buffering, a per-operation timeout and overflow reporting.

## Interface
Parameters:
- `DW`, 32: result/remainder width in bits.
- `N_UNITS`, 3: number of arithmetic units. Unit 0 = MULT, 1 = DIV, 2 = ROOT.
- `DEPTH`, 4: output FIFO entries; power of two, ≥ 2.
- `REM_MASK`, 3'b110: bit u = 1 means unit u produces a remainder. Where the bit is 0, the stored remainder is forced to 0.
- `TIMEOUT`, 64: maximum number of WAIT cycles before abort; 0 disables the timeout.
- Derived: `SEL_W` = $clog2(N_UNITS+1); `CW` = $clog2(DEPTH+1).

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  launch strobe; latches `i_sel`.
- `i_sel`  in  SEL_W  unit index; any value ≥ N_UNITS means NON.
- `i_result`  in  N_UNITS*DW  packed unit results; unit u occupies bits [u*DW +: DW].
- `i_remainder`  in  N_UNITS*DW  packed unit remainders, same packing.
- `i_ready`  in  N_UNITS  per-unit single-cycle done pulses.
- `i_accept`  in  1  consumer accepts the head entry.
- `o_result`  out  DW  head-entry result; 0 when empty.
- `o_remainder`  out  DW  head-entry remainder; 0 when empty.
- `o_valid`  out  1  FIFO not empty.
- `o_busy`  out  1  FSM in WAIT.
- `o_count`  out  CW  FIFO occupancy.
- `o_full`  out  1  occupancy == DEPTH.
- `o_timeout`  out  1  one-cycle pulse on a timeout abort.
- `o_overflow`  out  1  sticky; a capture was dropped because the FIFO was full. Cleared only by `rst`.

## Operation
- FSM states: IDLE and WAIT. Registers: `sel_q` (SEL_W bits), `tcnt` (width $clog2(TIMEOUT+1)), FIFO storage of 2*DW per entry, and read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- **IDLE:**
  - `i_start` with `i_sel` < N_UNITS: `sel_q` ← `i_sel`, `tcnt` ← 0, go to WAIT.
  - `i_start` with NON: no state change and no push.
  - All `i_ready` pulses are ignored.
- **WAIT:**
  - `i_start` is ignored.
  - Only `i_ready[sel_q]` is observed; pulses from other units are ignored.
  - On `i_ready[sel_q]`: push {`i_result[sel_q]`, remainder masked by `REM_MASK[sel_q]`}, then go to IDLE.
  - Without ready: `tcnt` increments. If TIMEOUT ≠ 0 and `tcnt` == TIMEOUT−1, go to IDLE and pulse `o_timeout` on the next cycle. No push occurs.
- **Push/pop rules:**
  - Pop = `o_valid` & `i_accept`.
  - Push when full with no pop in the same cycle: the data is dropped and `o_overflow` ← 1. The FSM still returns to IDLE.
  - Push when full with a simultaneous pop: allowed, and the count is unchanged.
  - Push and pop on a non-empty FIFO: the count is unchanged.
  - `i_accept` while empty: no effect.
- FIFO is first-word-fall-through. `o_result` and `o_remainder` are driven combinationally from the head entry, gated to 0 when empty.
- **Reset:**
  - State ← IDLE, pointers and count ← 0.
  - All outputs read 0, including `o_overflow`.
  - FIFO contents need not be cleared.
  - A reset during WAIT abandons the operation with no push.

## Timing
- `i_start` at cycle t: `o_busy` = 1 from t+1. An `i_ready` pulse at cycle t itself is ignored.
- `i_ready[sel_q]` at cycle t+k (k ≥ 1): `o_busy` = 0 and `o_valid` = 1 with the data at t+k+1. A new `i_start` is accepted at t+k+1.
- Timeout: the unit's ready is accepted only in WAIT cycles 1..TIMEOUT. With no ready in any of them, `o_timeout` = 1 and `o_busy` = 0 on the cycle after WAIT cycle TIMEOUT.
- A pop at cycle t exposes the next entry at t+1. `o_count`, `o_full` and `o_valid` are registered-state outputs and update one cycle after a push or pop.
- Throughput: at most one capture every 2 cycles (start, then ready); one pop per cycle.

## Test plan
- **Reset and basic MULT:** rst, then start `i_sel`=0. Ready[0] at t+3 with result 0x0000_0042 and remainder 0xDEAD → at t+4 `o_valid`=1, `o_result`=0x42, `o_remainder`=0 (masked).
- **DIV with stray ready:** start `i_sel`=1. Ready[2] pulses at t+1 → ignored, `o_busy` stays 1. Ready[1] at t+2 with 7/3 → `o_result`=7, `o_remainder`=3 at t+3.
- **Fill and overflow:** 4 captures with `i_accept`=0 → `o_full`=1, `o_count`=4. A 5th capture → `o_overflow`=1, `o_count`=4, and the head is still the first result.
- **Full with simultaneous pop:** FIFO full, capture and `i_accept` in the same cycle → `o_count` stays 4, and order across pointer wrap is preserved through 8 drains.
- **Timeout:** TIMEOUT=64, start `i_sel`=2 with no ready → `o_timeout` pulses exactly once, 65 cycles after start. `o_busy`=0 and no push. A late ready[2] is ignored.
- **NON and reset mid-WAIT:** start `i_sel`=3 → `o_busy` stays 0. Start `i_sel`=1, assert rst during WAIT → all outputs 0 next cycle, and a following ready[1] produces no push.
